// File: rtl/alu_acc_pkg.sv
// alu_acc_pkg: opcodes, ALU function codes and FSM states
// shared by alu_acc_ctrl and alu_acc_dec.
package alu_acc_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_PEEK = 3'd7;

  // SHR shares the idle code; the ALU shifts right on 0
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_SHR  = 5'b00000;
  localparam logic [4:0] F_ADD  = 5'b00010;
  localparam logic [4:0] F_SUB  = 5'b00011;
  localparam logic [4:0] F_AND  = 5'b01000;
  localparam logic [4:0] F_OR   = 5'b01100;
  localparam logic [4:0] F_SHL  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/alu_acc_dec.sv
// alu_acc_dec: opcode to ALU function code decoder.
// uses_alu_o marks opcodes whose result comes from alu_y.
module alu_acc_dec
  import alu_acc_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [4:0] f_o,
  output logic       uses_alu_o
);

  // map each opcode to its function code
  always_comb begin
    f_o        = F_NONE;
    uses_alu_o = 1'b1;
    case (op_i)
      OP_ADD:  f_o = F_ADD;
      OP_SUB:  f_o = F_SUB;
      OP_AND:  f_o = F_AND;
      OP_OR:   f_o = F_OR;
      OP_SHR:  f_o = F_SHR;
      OP_SHL:  f_o = F_SHL;
      default: begin
        f_o        = F_NONE;
        uses_alu_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: accumulator controller around an external ALU.
// Define ALU_ACC_CTRL_FLAGS_EN to add flag_z/flag_c outputs.
module alu_acc_ctrl
  import alu_acc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [3:0] in_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [4:0] alu_f,
  input  logic [3:0] alu_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       busy
`ifdef ALU_ACC_CTRL_FLAGS_EN
  ,
  output logic       flag_z,
  output logic       flag_c
`endif
);

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] opd_q, opd_d;
  logic [2:0] op_q, op_d;
  logic [4:0] dec_f;
  logic       dec_alu;
  logic       in_fire;
  logic       exec;

  alu_acc_dec u_dec (
    .op_i       (op_q),
    .f_o        (dec_f),
    .uses_alu_o (dec_alu)
  );

  assign in_fire = in_valid & in_ready;
  assign exec    = (state_q == ST_EXEC);

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= 4'd0;
      opd_q   <= 4'd0;
      op_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      op_q    <= op_d;
    end
  end

  // next state: one EXEC cycle, EMIT until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_fire)   state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_EMIT;
      ST_EMIT: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // handshake and ALU control outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_EMIT);
    alu_f     = exec ? dec_f : F_NONE;
  end

  assign alu_a    = acc_q;
  assign alu_b    = opd_q;
  assign out_data = acc_q;

  // latch the instruction, then update acc in EXEC
  always_comb begin
    op_d  = op_q;
    opd_d = opd_q;
    acc_d = acc_q;
    if (in_fire) begin
      op_d  = in_op;
      opd_d = in_data;
    end
    if (exec) begin
      if (dec_alu)
        acc_d = alu_y;
      else if (op_q == OP_LOAD)
        acc_d = opd_q;
    end
  end

`ifdef ALU_ACC_CTRL_FLAGS_EN
  logic z_q, z_d;
  logic c_q, c_d;

  // flags follow the new acc; PEEK holds them
  always_comb begin
    z_d = z_q;
    c_d = c_q;
    if (exec && op_q != OP_PEEK) begin
      z_d = (acc_d == 4'd0);
      case (op_q)
        OP_ADD:
          c_d = ({1'b0, acc_q} + {1'b0, opd_q})
                > 5'd15;
        OP_SUB:  c_d = (acc_q < opd_q);
        OP_SHL:  c_d = acc_q[3];
        OP_SHR:  c_d = acc_q[0];
        default: c_d = 1'b0;
      endcase
    end
  end

  // flag registers, updated alongside acc
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  assign flag_z = z_q;
  assign flag_c = c_q;
`endif

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// tb_alu_acc_ctrl: directed table, corner sequences and
// random instructions against an arithmetic acc model.
module tb_alu_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_f;
  logic [3:0] alu_y;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
`ifdef ALU_ACC_CTRL_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
`endif

  int n_run  = 0;
  int n_fail = 0;

  int m_acc = 0;
  int m_z   = 0;
  int m_c   = 0;

  typedef struct {
    int op;
    int d;
    int y;
    int f;
    int z;
    int c;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  alu_acc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_y     (alu_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef ALU_ACC_CTRL_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_c    (flag_c)
`endif
  );

  // external ALU
  always_comb begin
    alu_y = 4'd0;
    case (alu_f)
      5'b00010: alu_y = alu_a + alu_b;
      5'b00011: alu_y = alu_a - alu_b;
      5'b01000: alu_y = alu_a & alu_b;
      5'b01100: alu_y = alu_a | alu_b;
      5'b10000: alu_y = alu_a << 1;
      default:  alu_y = alu_a >> 1;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  function automatic int exp_f(input int op);
    case (op)
      1:       return 2;
      2:       return 3;
      3:       return 8;
      4:       return 12;
      6:       return 16;
      default: return 0;
    endcase
  endfunction

  function automatic void model(input int op,
                                input int d);
    int a;
    int r;
    int c;
    if (op == 7) return;
    a = m_acc;
    r = 0;
    c = 0;
    case (op)
      0: r = d;
      1: begin
        r = (a + d) % 16;
        c = (a + d > 15) ? 1 : 0;
      end
      2: begin
        r = (a - d + 16) % 16;
        c = (a < d) ? 1 : 0;
      end
      3: r = a & d;
      4: r = a | d;
      5: begin
        r = a / 2;
        c = a % 2;
      end
      default: begin
        r = (a * 2) % 16;
        c = a / 8;
      end
    endcase
    m_acc = r;
    m_c   = c;
    m_z   = (r == 0) ? 1 : 0;
  endfunction

  // hold until accepted; returns in the EXEC cycle
  task automatic accept(input int op, input int d);
    in_op    = 3'(op);
    in_data  = 4'(d);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++)
      step();
    chk("accept_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_flags(input string nm,
                           input int z,
                           input int c);
`ifdef ALU_ACC_CTRL_FLAGS_EN
    chk({nm, "_z"}, int'(flag_z), z);
    chk({nm, "_c"}, int'(flag_c), c);
`else
    if (nm.len() == 0 && z == c) return;
`endif
  endtask

  task automatic drain(input string nm,
                       input int exp,
                       input int z,
                       input int c);
    for (int i = 0; i < 20 && !out_valid; i++)
      step();
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_data"}, int'(out_data), exp);
    chk_flags(nm, z, c);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({nm, "_idle"}, int'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_data   = 4'd0;
    out_ready = 1'b0;

    tbl[0]  = '{0, 9, 9, 0, 0, 0};
    tbl[1]  = '{0, 15, 15, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 2, 1, 1};
    tbl[3]  = '{0, 0, 0, 0, 1, 0};
    tbl[4]  = '{2, 1, 15, 3, 0, 1};
    tbl[5]  = '{0, 10, 10, 0, 0, 0};
    tbl[6]  = '{6, 1, 4, 16, 0, 1};
    tbl[7]  = '{5, 1, 2, 0, 0, 0};
    tbl[8]  = '{3, 3, 2, 8, 0, 0};
    tbl[9]  = '{4, 5, 7, 12, 0, 0};
    tbl[10] = '{7, 0, 7, 0, 0, 0};
    tbl[11] = '{1, 9, 0, 2, 1, 1};
    tbl[12] = '{7, 4, 0, 0, 1, 1};
    tbl[13] = '{2, 0, 0, 3, 1, 0};

    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_acc", int'(out_data), 0);
    chk("rst_alu_b", int'(alu_b), 0);
    chk("rst_alu_f", int'(alu_f), 0);
    chk_flags("rst", 0, 0);

    // directed table, exact N+2 latency
    for (int i = 0; i < 14; i++) begin
      accept(tbl[i].op, tbl[i].d);
      model(tbl[i].op, tbl[i].d);
      chk("tbl_exec_f", int'(alu_f), tbl[i].f);
      chk("tbl_exec_b", int'(alu_b), tbl[i].d);
      chk("tbl_exec_busy", int'(busy), 1);
      chk("tbl_exec_ov", int'(out_valid), 0);
      step();
      chk("tbl_emit_f", int'(alu_f), 0);
      drain("tbl", tbl[i].y, tbl[i].z, tbl[i].c);
    end

    // stall in EMIT with ignored in_valid pulses
    accept(0, 6);
    model(0, 6);
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_op    = 3'd1;
      in_data  = 4'd3;
      chk("stall_ov", int'(out_valid), 1);
      chk("stall_data", int'(out_data), 6);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_alu_b", int'(alu_b), 6);
      step();
    end
    in_valid = 1'b0;
    drain("stall", 6, 0, 0);
    accept(7, 0);
    step();
    drain("stall_peek", 6, 0, 0);

    // reset during EXEC discards the ADD
    accept(0, 4);
    step();
    drain("pre_rst", 4, 0, 0);
    accept(1, 3);
    chk("rst_exec_f", int'(alu_f), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_acc = 0;
    m_z   = 0;
    m_c   = 0;
    chk("rst_exec_idle", int'(in_ready), 1);
    chk("rst_exec_busy", int'(busy), 0);
    chk("rst_exec_acc", int'(out_data), 0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_exec_noout", int'(out_valid), 0);
      step();
    end
    accept(7, 0);
    step();
    drain("rst_peek", 0, 0, 0);

    // reset wins over output handshake in EMIT
    accept(0, 5);
    step();
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("rst_emit_ov", int'(out_valid), 0);
    chk("rst_emit_acc", int'(out_data), 0);
    chk_flags("rst_emit", 0, 0);

    // random instructions against the model
    for (int k = 0; k < 300; k++) begin
      int op;
      int d;
      int w;
      op = int'($urandom_range(0, 7));
      d  = int'($urandom_range(0, 15));
      w  = int'($urandom_range(0, 3));
      for (int i = 0; i < w % 2; i++) step();
      accept(op, d);
      model(op, d);
      chk("rnd_f", int'(alu_f), exp_f(op));
      step();
      for (int i = 0; i < w; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 4'($urandom_range(0, 15));
        chk("rnd_hold", int'(out_data), m_acc);
        step();
      end
      in_valid = 1'b0;
      drain("rnd", m_acc, m_z, m_c);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_ctrl.md
ALU_ACC_CTRL -- requirements
Module: alu_acc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: instruction offered.
REQ-004 SHALL have port in_ready, output, 1 bit: instruction accepted when in_valid and in_ready are both high.
REQ-005 SHALL have port in_op, input, 3 bits: opcode. 0 LOAD, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SHR, 6 SHL, 7 PEEK.
REQ-006 SHALL have port in_data, input, 4 bits: operand.
REQ-007 SHALL have port alu_a, output, 4 bits: ALU operand a; always equals acc.
REQ-008 SHALL have port alu_b, output, 4 bits: ALU operand b; equals the registered operand.
REQ-009 SHALL have port alu_f, output, 5 bits: ALU function code.
REQ-010 SHALL have port alu_y, input, 4 bits: combinational ALU result.
REQ-011 SHALL have port out_valid, output, 1 bit: result token valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts token.
REQ-013 SHALL have port out_data, output, 4 bits: accumulator value after the instruction.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, EMIT, with in_ready high only in IDLE.
REQ-016 IDLE SHALL latch in_op and in_data on handshake and go to EXEC; without a handshake it SHALL stay in IDLE.
REQ-017 EXEC SHALL last exactly one cycle, drive alu_f from the latched opcode, and update acc at the end of that cycle; next state is EMIT.
REQ-018 The alu_f map SHALL be: ADD 5'b00010, SUB 5'b00011, AND 5'b01000, OR 5'b01100, SHR 5'b00000, SHL 5'b10000; LOAD and PEEK drive 5'b00000 and ignore alu_y.
REQ-019 Accumulator updates SHALL be: LOAD sets acc to the operand; PEEK leaves acc unchanged; every other opcode sets acc to alu_y.
REQ-020 Arithmetic SHALL be modulo 16: 15+1 gives 0, and 0-1 gives 15. Shifts are by one bit with zero-fill.
REQ-021 EMIT SHALL hold out_valid high with out_data equal to acc, stable until out_ready is sampled high; on that handshake it SHALL go to IDLE.
REQ-022 Latency SHALL be: accept at cycle N, then out_valid is high from cycle N+2. Maximum throughput is one instruction per 3 cycles.
REQ-023 out_ready high while out_valid is low SHALL have no effect; in_valid while busy SHALL be ignored and not queued.
REQ-024 Outside EXEC, alu_f SHALL be 5'b00000 and alu_b SHALL hold its last value.

Reset
REQ-025 On rst, the block SHALL set: state IDLE, acc 0, operand register 0, opcode register 0, out_valid 0, busy 0, in_ready 1 (from the cycle after reset deasserts).
REQ-026 rst in EXEC or EMIT SHALL discard the in-flight instruction and token with no output emitted; rst has priority over all handshakes in the same cycle.

Configuration
REQ-027 With macro ALU_ACC_CTRL_FLAGS_EN defined, the block SHALL add outputs flag_z (1 bit) and flag_c (1 bit), registered with acc and reset to 0.
- flag_z = (new acc == 0).
- flag_c = bit 4 of the 5-bit sum for ADD, or borrow (a<b) for SUB; SHL gives the old acc[3], SHR gives the old acc[0].
- LOAD, AND and OR clear flag_c; PEEK holds both flags.
REQ-028 Without ALU_ACC_CTRL_FLAGS_EN, the flag ports and the flag logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 The shared package alu_acc_pkg SHALL hold:
- the opcode constants;
- the five 5-bit ALU function-code constants;
- the FSM state encoding.
REQ-030 Opcode-to-alu_f decoding SHALL be a combinational sub-module alu_acc_dec (in_op to alu_f plus a uses_alu bit). The ALU itself stays external.

Verification
REQ-031 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset, then LOAD 4'h9 -> out_data 9 at cycle N+2; flag_z 0 when the flags macro is defined.
- LOAD F then ADD 1 -> out_data 0; flag_z 1 and flag_c 1.
- LOAD 0 then SUB 1 -> out_data F, flag_c 1; alu_f observed as 5'b00011 during EXEC.
- LOAD A, then SHL 1 -> 4; then SHR 1 -> 2; then AND 3 -> 2; then OR 5 -> 7.
- out_ready held low for 5 cycles in EMIT -> out_valid and out_data stable; in_ready 0; in_valid pulses ignored; acc unchanged.
- rst asserted during EXEC of ADD 3 after LOAD 4 -> no token emitted; next PEEK returns 0.
